automatic_washing_machine_system: RTL and testbench

Controller FSM for a front-loading washing machine. It sequences the door lock, fill valve, drain valve and motor through fill, detergent, wash, drain and spin phases. Phases advance on sensor and timer handshake inputs from the plant and external timers, and completion is reported on `done`. The block sits between the user panel/sensors and the actuator drivers; it has no internal timers.

---
 rtl/automatic_washing_machine_system_pkg.sv | 25 ++
 rtl/automatic_washing_machine_system_output_decode.sv | 54 +++++
 rtl/automatic_washing_machine_system.sv | 63 ++++++
 tb/tb_automatic_washing_machine_system.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/automatic_washing_machine_system_pkg.sv
// Shared types for the washing machine controller: phase encoding and output bundle.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package washer_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    CHECK_DOOR    = 3'd1,
    FILL_WATER    = 3'd2,
    ADD_DETERGENT = 3'd3,
    WASH          = 3'd4,
    DRAIN_WATER   = 3'd5,
    SPIN          = 3'd6,
    DONE          = 3'd7
  } washer_state_t;

  typedef struct packed {
    logic door_lock;
    logic motor_on;
    logic fill_valve_on;
    logic drain_valve_on;
    logic done;
  } washer_out_t;

endpackage

// File: rtl/automatic_washing_machine_system_output_decode.sv
// Combinational map from controller phase to the five actuator/status outputs.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the state input directly.
module washer_output_decode
  import washer_pkg::*;
(
  input  logic [2:0] state_i,
  output logic       door_lock_o,
  output logic       motor_on_o,
  output logic       fill_valve_on_o,
  output logic       drain_valve_on_o,
  output logic       done_o
);

  washer_out_t out_s;

  // Decode each phase to its actuator set; everything not listed stays off.
  always_comb begin
    out_s = '0;
    case (washer_state_t'(state_i))
      FILL_WATER: begin
        out_s.door_lock     = 1'b1;
        out_s.fill_valve_on = 1'b1;
      end
      ADD_DETERGENT: begin
        out_s.door_lock = 1'b1;
      end
      WASH: begin
        out_s.door_lock = 1'b1;
        out_s.motor_on  = 1'b1;
      end
      DRAIN_WATER: begin
        out_s.door_lock      = 1'b1;
        out_s.drain_valve_on = 1'b1;
      end
      SPIN: begin
        out_s.door_lock      = 1'b1;
        out_s.motor_on       = 1'b1;
        out_s.drain_valve_on = 1'b1;
      end
      DONE: begin
        out_s.done = 1'b1;
      end
      default: out_s = '0;
    endcase
  end

  assign door_lock_o      = out_s.door_lock;
  assign motor_on_o       = out_s.motor_on;
  assign fill_valve_on_o  = out_s.fill_valve_on;
  assign drain_valve_on_o = out_s.drain_valve_on;
  assign done_o           = out_s.done;

endmodule

// File: rtl/automatic_washing_machine_system.sv
// Moore sequencer for a front-loader: door check, fill, detergent, wash, drain, spin, done.
// Latency: one clock from a sampled exit input to the new phase's outputs.
// Backpressure: none; each phase waits on its own handshake input, done holds until start drops.
module automatic_washing_machine_system
  import washer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic door_close,
  input  logic filled,
  input  logic detergent_added,
  input  logic cycle_timeout,
  input  logic drained,
  input  logic spin_timeout,
  output logic door_lock,
  output logic motor_on,
  output logic fill_valve_on,
  output logic drain_valve_on,
  output logic done
);

  washer_state_t state_q;
  washer_state_t state_d;

  // State register; reset is asynchronous and low-active so actuators drop without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: each phase looks only at its own exit input, no edge detection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          if (start)           state_d = CHECK_DOOR;
      CHECK_DOOR: begin
        if (door_close)      state_d = FILL_WATER;
        else if (!start)     state_d = IDLE;
      end
      FILL_WATER:    if (filled)          state_d = ADD_DETERGENT;
      ADD_DETERGENT: if (detergent_added) state_d = WASH;
      WASH:          if (cycle_timeout)   state_d = DRAIN_WATER;
      DRAIN_WATER:   if (drained)         state_d = SPIN;
      SPIN:          if (spin_timeout)    state_d = DONE;
      DONE:          if (!start)          state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  washer_output_decode u_decode (
    .state_i          (state_q),
    .door_lock_o      (door_lock),
    .motor_on_o       (motor_on),
    .fill_valve_on_o  (fill_valve_on),
    .drain_valve_on_o (drain_valve_on),
    .done_o           (done)
  );

endmodule

// File: tb/tb_automatic_washing_machine_system.sv
module tb_automatic_washing_machine_system;

  logic clk = 1'b0;
  logic rst;
  logic start, door_close, filled, detergent_added, cycle_timeout, drained, spin_timeout;
  logic door_lock, motor_on, fill_valve_on, drain_valve_on, done;

  int checks = 0;
  int errors = 0;

  // Reference: phase number 0..7 in program order (idle, door check, fill, detergent,
  // wash, drain, spin, done).
  int phase = 0;

  automatic_washing_machine_system dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .door_close      (door_close),
    .filled          (filled),
    .detergent_added (detergent_added),
    .cycle_timeout   (cycle_timeout),
    .drained         (drained),
    .spin_timeout    (spin_timeout),
    .door_lock       (door_lock),
    .motor_on        (motor_on),
    .fill_valve_on   (fill_valve_on),
    .drain_valve_on  (drain_valve_on),
    .done            (done)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {door_lock, motor_on, fill_valve_on, drain_valve_on, done};
  endfunction

  // Expected {door_lock, motor_on, fill, drain, done} for a program phase.
  function automatic logic [4:0] exp_outs(int p);
    logic [4:0] e;
    e[4] = (p >= 2 && p <= 6);
    e[3] = (p == 4 || p == 6);
    e[2] = (p == 2);
    e[1] = (p == 5 || p == 6);
    e[0] = (p == 7);
    return e;
  endfunction

  function automatic int model_next(int p);
    logic exit_in [0:7];
    exit_in[0] = start;
    exit_in[1] = door_close;
    exit_in[2] = filled;
    exit_in[3] = detergent_added;
    exit_in[4] = cycle_timeout;
    exit_in[5] = drained;
    exit_in[6] = spin_timeout;
    exit_in[7] = !start;
    if (p == 1 && !door_close) return start ? 1 : 0;
    if (!exit_in[p]) return p;
    return (p == 7) ? 0 : p + 1;
  endfunction

  task automatic set_in(input logic [6:0] v);
    {start, door_close, filled, detergent_added, cycle_timeout, drained, spin_timeout} = v;
  endtask

  // Advance one clock edge, update the reference, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) phase = 0;
    else      phase = model_next(phase);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(7'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    phase = 0;
  endtask

  task automatic test_reset();
    set_in(7'h7f);
    rst = 1'b0;
    #1;
    checks++;
    if (outs() !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold_immediate: outs=%b expected=%b", outs(), 5'b0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs() !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold_cycle%0d: outs=%b expected=%b", i, outs(), 5'b0);
      end
    end
    set_in(7'b0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (outs() !== 5'b0 || phase != 0) begin
        errors++;
        $display("FAIL reset_release_idle%0d: outs=%b expected=%b phase=%0d", i, outs(), 5'b0, phase);
      end
    end
  endtask

  task automatic test_nominal();
    logic [4:0] seen [2:7];
    logic [6:0] v;
    do_reset();
    v = 7'b1100000;
    set_in(v);
    for (int step = 0; step < 5; step++) begin
      int wait_n = $urandom_range(2, 4);
      for (int c = 0; c < wait_n; c++) begin
        tick();
        checks++;
        if (outs() !== exp_outs(phase)) begin
          errors++;
          $display("FAIL nominal_phase%0d: outs=%b expected=%b", phase, outs(), exp_outs(phase));
        end
        if (phase >= 2) seen[phase] = outs();
      end
      v[4 - step] = 1'b1;
      set_in(v);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (phase >= 2) seen[phase] = outs();
    end
    checks++;
    if (seen[2] !== 5'b10100) begin errors++; $display("FAIL nominal_fill: outs=%b expected=%b", seen[2], 5'b10100); end
    checks++;
    if (seen[3] !== 5'b10000) begin errors++; $display("FAIL nominal_detergent: outs=%b expected=%b", seen[3], 5'b10000); end
    checks++;
    if (seen[4] !== 5'b11000) begin errors++; $display("FAIL nominal_wash: outs=%b expected=%b", seen[4], 5'b11000); end
    checks++;
    if (seen[5] !== 5'b10010) begin errors++; $display("FAIL nominal_drain: outs=%b expected=%b", seen[5], 5'b10010); end
    checks++;
    if (seen[6] !== 5'b11010) begin errors++; $display("FAIL nominal_spin: outs=%b expected=%b", seen[6], 5'b11010); end
    checks++;
    if (seen[7] !== 5'b00001 || outs() !== 5'b00001) begin
      errors++;
      $display("FAIL nominal_done: outs=%b expected=%b", outs(), 5'b00001);
    end
  endtask

  task automatic test_all_high();
    rst = 1'b0;
    set_in(7'h7f);
    #1;
    @(negedge clk);
    rst = 1'b1;
    phase = 0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (done !== (e == 7)) begin
        errors++;
        $display("FAIL all_high_edge%0d: done=%b expected=%b", e, done, (e == 7));
      end
    end
  endtask

  task automatic test_door_open();
    do_reset();
    set_in(7'b1000000);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (door_lock !== 1'b0 || fill_valve_on !== 1'b0) begin
        errors++;
        $display("FAIL door_open%0d: lock=%b fill=%b expected 0 0", i, door_lock, fill_valve_on);
      end
    end
    door_close = 1'b1;
    tick();
    checks++;
    if (fill_valve_on !== 1'b1 || door_lock !== 1'b1) begin
      errors++;
      $display("FAIL door_close_fill: lock=%b fill=%b expected 1 1", door_lock, fill_valve_on);
    end
  endtask

  task automatic test_reset_mid_wash();
    do_reset();
    set_in(7'b1111000);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (outs() !== 5'b11000 || phase != 4) begin
      errors++;
      $display("FAIL reach_wash: outs=%b expected=%b", outs(), 5'b11000);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (motor_on !== 1'b0 || door_lock !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_wash: motor=%b lock=%b expected 0 0", motor_on, door_lock);
    end
    phase = 0;
    set_in(7'b0);
    #1;
    rst = 1'b1;
    tick();
    checks++;
    if (outs() !== 5'b0 || phase != 0) begin
      errors++;
      $display("FAIL after_reset_idle: outs=%b expected=%b", outs(), 5'b0);
    end
    start = 1'b1;
    tick();
    tick();
    checks++;
    if (outs() !== 5'b0) begin
      errors++;
      $display("FAIL idle_no_door: outs=%b expected=%b", outs(), 5'b0);
    end
  endtask

  task automatic test_done_hold();
    do_reset();
    set_in(7'h7f);
    for (int i = 0; i < 7; i++) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done !== 1'b1 || door_lock !== 1'b0) begin
        errors++;
        $display("FAIL done_hold%0d: done=%b lock=%b expected 1 0", i, done, door_lock);
      end
    end
    start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_release: done=%b expected=%b", done, 1'b0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [6:0] v;
      v = 7'($urandom);
      v[6] = ($urandom_range(0, 99) < 85);
      set_in(v);
      tick();
      checks++;
      if (outs() !== exp_outs(phase)) begin
        errors++;
        $display("FAIL random_cycle%0d: outs=%b expected=%b phase=%0d", i, outs(), exp_outs(phase), phase);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    set_in(7'b0);
    @(negedge clk);
    test_reset();
    test_nominal();
    test_all_high();
    test_door_open();
    test_reset_mid_wash();
    test_done_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
